// File: rtl/axi_node_pkg.sv
// Shared definitions for the AXI node: the write-route FIFO entry and response codes.
// Entry fields are sized for the widest supported configuration; users fill the low bits.
package axi_node_pkg;

  localparam int unsigned ROUTE_DEST_W_MAX = 8;
  localparam int unsigned ROUTE_ID_W_MAX   = 32;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic                        err;
    logic [ROUTE_DEST_W_MAX-1:0] dest;
    logic [ROUTE_ID_W_MAX-1:0]   id;
  } route_entry_t;

endpackage

// File: rtl/axi_aw_route_fifo.sv
// Synchronous FIFO of outstanding write routes; DEPTH must be a power of two so the
// pointers wrap naturally.
module axi_aw_route_fifo
  import axi_node_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  route_entry_t data_i,
  output route_entry_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  route_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  // A pop never frees space for a push in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_aw_w_router.sv
// Address-decoded AW/W router: steers write bursts to one of N_INIT_PORT destinations in
// AW order, and absorbs undecodable bursts locally with a DECERR write response.
module axi_aw_w_router
  import axi_node_pkg::*;
#(
  parameter int unsigned AXI_ADDRESS_W = 32,
  parameter int unsigned AXI_ID_IN     = 16,
  parameter int unsigned N_INIT_PORT   = 5,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned LOG_N_INIT    = $clog2(N_INIT_PORT)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [AXI_ID_IN-1:0]               awid_i,
  input  logic [AXI_ADDRESS_W-1:0]           awaddr_i,
  input  logic                               awvalid_i,
  output logic                               awready_o,
  output logic [N_INIT_PORT-1:0]             awvalid_o,
  input  logic [N_INIT_PORT-1:0]             awready_i,
  input  logic                               wvalid_i,
  input  logic                               wlast_i,
  output logic                               wready_o,
  output logic [N_INIT_PORT-1:0]             wvalid_o,
  input  logic [N_INIT_PORT-1:0]             wready_i,
  input  logic [N_INIT_PORT*AXI_ADDRESS_W-1:0] start_addr_i,
  input  logic [N_INIT_PORT*AXI_ADDRESS_W-1:0] end_addr_i,
  input  logic [N_INIT_PORT-1:0]             enable_region_i,
  input  logic [N_INIT_PORT-1:0]             connectivity_map_i,
  output logic                               err_bvalid_o,
  input  logic                               err_bready_i,
  output logic [AXI_ID_IN-1:0]               err_bid_o
);

  logic                  hit;
  logic [LOG_N_INIT-1:0] hit_dest;
  logic                  aw_hs;
  logic                  w_pop;
  logic                  fifo_full, fifo_empty;
  route_entry_t          push_entry, head;
  logic [LOG_N_INIT-1:0] head_dest;
  logic [AXI_ID_IN-1:0]  head_id;
  logic                  err_bvalid_q, err_bvalid_d;
  logic [AXI_ID_IN-1:0]  err_bid_q, err_bid_d;
  logic                  unused_head_bits;

  // Iterating downwards lets the lowest matching region overwrite higher ones.
  always_comb begin
    hit      = 1'b0;
    hit_dest = '0;
    for (int i = N_INIT_PORT - 1; i >= 0; i--) begin
      if (enable_region_i[i] && connectivity_map_i[i] &&
          (start_addr_i[i*AXI_ADDRESS_W +: AXI_ADDRESS_W] <= awaddr_i) &&
          (awaddr_i <= end_addr_i[i*AXI_ADDRESS_W +: AXI_ADDRESS_W])) begin
        hit      = 1'b1;
        hit_dest = LOG_N_INIT'(i);
      end
    end
  end

  always_comb begin
    awvalid_o = '0;
    awready_o = 1'b0;
    if (rst_n && !fifo_full) begin
      if (hit) begin
        awvalid_o[hit_dest] = awvalid_i;
        awready_o           = awready_i[hit_dest];
      end else begin
        awready_o = 1'b1;
      end
    end
  end

  assign aw_hs = awvalid_i & awready_o;

  always_comb begin
    push_entry                       = '0;
    push_entry.err                   = ~hit;
    push_entry.dest[LOG_N_INIT-1:0]  = hit_dest;
    push_entry.id[AXI_ID_IN-1:0]     = awid_i;
  end

  axi_aw_route_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (aw_hs),
    .pop_i   (w_pop),
    .data_i  (push_entry),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_dest        = head.dest[LOG_N_INIT-1:0];
  assign head_id          = head.id[AXI_ID_IN-1:0];
  assign unused_head_bits = ^head;

  // W is steered only by the registered FIFO head, so there is no AW-to-W path.
  always_comb begin
    wvalid_o = '0;
    wready_o = 1'b0;
    if (!fifo_empty) begin
      if (head.err) begin
        wready_o = ~err_bvalid_q;
      end else begin
        wvalid_o[head_dest] = wvalid_i;
        wready_o            = wready_i[head_dest];
      end
    end
    w_pop = ~fifo_empty & wvalid_i & wready_o & wlast_i;
  end

  // An errored burst cannot complete while a previous DECERR is pending, so set and clear never collide.
  always_comb begin
    err_bvalid_d = err_bvalid_q;
    err_bid_d    = err_bid_q;
    if (err_bvalid_q && err_bready_i) err_bvalid_d = 1'b0;
    if (w_pop && head.err) begin
      err_bvalid_d = 1'b1;
      err_bid_d    = head_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_bvalid_q <= 1'b0;
      err_bid_q    <= '0;
    end else begin
      err_bvalid_q <= err_bvalid_d;
      err_bid_q    <= err_bid_d;
    end
  end

  assign err_bvalid_o = err_bvalid_q;
  assign err_bid_o    = err_bid_q;

endmodule

// File: tb/tb_axi_aw_w_router.sv
// Directed and randomized bench for axi_aw_w_router; the random phase is checked against a
// queue-based model of outstanding bursts.
module tb_axi_aw_w_router;

  localparam int AW = 32;
  localparam int IDW = 16;
  localparam int N = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IDW-1:0] awid_i;
  logic [AW-1:0] awaddr_i;
  logic awvalid_i, awready_o;
  logic [N-1:0] awvalid_o, awready_i;
  logic wvalid_i, wlast_i, wready_o;
  logic [N-1:0] wvalid_o, wready_i;
  logic [N*AW-1:0] start_addr_i, end_addr_i;
  logic [N-1:0] enable_region_i, connectivity_map_i;
  logic err_bvalid_o, err_bready_i;
  logic [IDW-1:0] err_bid_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] r_st [N];
  logic [31:0] r_end [N];
  bit r_ena [N];
  bit r_conn [N];

  typedef struct {
    bit err;
    int dest;
    int id;
  } ent_t;

  always #5 clk = ~clk;

  axi_aw_w_router #(
    .AXI_ADDRESS_W(AW), .AXI_ID_IN(IDW), .N_INIT_PORT(N), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .awid_i(awid_i), .awaddr_i(awaddr_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wvalid_i(wvalid_i), .wlast_i(wlast_i), .wready_o(wready_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i), .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
    .enable_region_i(enable_region_i), .connectivity_map_i(connectivity_map_i),
    .err_bvalid_o(err_bvalid_o), .err_bready_i(err_bready_i), .err_bid_o(err_bid_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    awvalid_i = 1'b0;
    wvalid_i = 1'b0;
    wlast_i = 1'b0;
    err_bready_i = 1'b0;
    awready_i = '1;
    wready_i = '1;
  endtask

  task automatic apply_regions();
    for (int i = 0; i < N; i++) begin
      start_addr_i[i*AW +: AW] = r_st[i];
      end_addr_i[i*AW +: AW] = r_end[i];
      enable_region_i[i] = r_ena[i];
      connectivity_map_i[i] = r_conn[i];
    end
  endtask

  function automatic void m_decode(input logic [31:0] a, output bit hit, output int d);
    hit = 1'b0;
    d = 0;
    for (int i = 0; i < N; i++)
      if (!hit && r_ena[i] && r_conn[i] && a >= r_st[i] && a <= r_end[i]) begin
        hit = 1'b1;
        d = i;
      end
  endfunction

  function automatic logic [N-1:0] onehot(input int d);
    logic [N-1:0] v;
    v = '0;
    v[d] = 1'b1;
    return v;
  endfunction

  // Random-phase model state
  ent_t q[$];
  ent_t e;
  bit m_errv;
  int m_eid;
  bit m_hit, m_full, aw_hs, pop;
  int m_d;
  logic [N-1:0] exp_awv, exp_wv;
  logic exp_awr, exp_wr;
  logic [31:0] bnd [8];

  initial begin
    r_st[0] = 32'h0000; r_end[0] = 32'h0FFF; r_ena[0] = 1; r_conn[0] = 1;
    r_st[1] = 32'h2000; r_end[1] = 32'h2FFF; r_ena[1] = 1; r_conn[1] = 1;
    r_st[2] = 32'h1000; r_end[2] = 32'h1FFF; r_ena[2] = 1; r_conn[2] = 1;
    r_st[3] = 32'h1F00; r_end[3] = 32'h20FF; r_ena[3] = 1; r_conn[3] = 1;
    r_st[4] = 32'h3000; r_end[4] = 32'h3FFF; r_ena[4] = 1; r_conn[4] = 0;
    apply_regions();
    idle();
    awid_i = '0;
    awaddr_i = '0;

    // Reset with live upstream traffic
    rst_n = 1'b0;
    awvalid_i = 1'b1; awaddr_i = 32'h1800; wvalid_i = 1'b1;
    edge_(); edge_();
    chk("rst_awvalid_o", awvalid_o, 0);
    chk("rst_wvalid_o", wvalid_o, 0);
    chk("rst_wready_o", wready_o, 0);
    chk("rst_err_bvalid", err_bvalid_o, 0);
    chk("rst_err_bid", err_bid_o, 0);
    idle(); wvalid_i = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_wready", wready_o, 0);
    chk("post_rst_wvalid", wvalid_o, 0);

    // Region 2 burst of four beats
    edge_();
    awvalid_i = 1; awaddr_i = 32'h1800; awid_i = 16'h1; wvalid_i = 1; wlast_i = 0;
    #1;
    chk("r2_awvalid_o", awvalid_o, 5'b00100);
    chk("r2_awready_o", awready_o, 1);
    chk("w_before_aw_wvalid", wvalid_o, 0);
    chk("w_before_aw_wready", wready_o, 0);
    edge_();
    awvalid_i = 0;
    for (int b = 1; b <= 4; b++) begin
      if (b == 2) begin
        wready_i = 5'b11011; wvalid_i = 1; wlast_i = 0;
        #1;
        chk("r2_stall_wready", wready_o, 0);
        chk("r2_stall_wvalid", wvalid_o, 5'b00100);
        edge_();
        wready_i = '1;
      end
      wvalid_i = 1; wlast_i = (b == 4);
      #1;
      chk("r2_beat_wvalid", wvalid_o, 5'b00100);
      chk("r2_beat_wready", wready_o, 1);
      edge_();
    end
    wlast_i = 0;
    #1;
    chk("r2_drained_wready", wready_o, 0);
    chk("r2_drained_wvalid", wvalid_o, 0);

    // Overlapping regions 1 and 3: lowest index wins
    edge_();
    wvalid_i = 0;
    awvalid_i = 1; awaddr_i = 32'h2000; awid_i = 16'h2; awready_i = 5'b11101;
    #1;
    chk("ovl_awvalid_o", awvalid_o, 5'b00010);
    chk("ovl_awready_low", awready_o, 0);
    edge_();
    awready_i = '1;
    #1;
    chk("ovl_awready_high", awready_o, 1);
    edge_();
    awvalid_i = 0; wvalid_i = 1; wlast_i = 1;
    #1;
    chk("ovl_wvalid_o", wvalid_o, 5'b00010);
    edge_();
    idle();

    // Enable and connectivity gating turn matches into errors
    awready_i = '0; awaddr_i = 32'h3800;
    #1;
    chk("noconn_awready", awready_o, 1);
    r_ena[0] = 0; apply_regions(); awaddr_i = 32'h0800;
    #1;
    chk("disabled_awready", awready_o, 1);
    r_ena[0] = 1; apply_regions();
    #1;
    chk("enabled_awready", awready_o, 0);

    // Decode error: local accept, beats discarded, DECERR response
    edge_();
    awvalid_i = 1; awaddr_i = 32'hF000; awid_i = 16'h5;
    #1;
    chk("err_awready", awready_o, 1);
    chk("err_awvalid_o", awvalid_o, 0);
    edge_();
    awvalid_i = 0; wready_i = '1; wvalid_i = 1; wlast_i = 0;
    #1;
    chk("err_b1_wready", wready_o, 1);
    chk("err_b1_wvalid", wvalid_o, 0);
    edge_();
    wlast_i = 1;
    #1;
    chk("err_b2_wready", wready_o, 1);
    chk("err_b2_wvalid", wvalid_o, 0);
    edge_();
    idle();
    #1;
    chk("err_bvalid_set", err_bvalid_o, 1);
    chk("err_bid", err_bid_o, 16'h5);
    awvalid_i = 1; awaddr_i = 32'hF000; awid_i = 16'h9;
    edge_();
    awvalid_i = 0; wvalid_i = 1; wlast_i = 1;
    #1;
    chk("err_blocked_wready", wready_o, 0);
    edge_();
    chk("err_bvalid_held", err_bvalid_o, 1);
    chk("err_bid_held", err_bid_o, 16'h5);
    err_bready_i = 1;
    edge_();
    err_bready_i = 0;
    #1;
    chk("err_bvalid_cleared", err_bvalid_o, 0);
    chk("err2_wready", wready_o, 1);
    edge_();
    wvalid_i = 0; wlast_i = 0;
    #1;
    chk("err2_bvalid", err_bvalid_o, 1);
    chk("err2_bid", err_bid_o, 16'h9);
    err_bready_i = 1;
    edge_();
    idle();
    #1;
    chk("err2_bvalid_cleared", err_bvalid_o, 0);

    // Full FIFO blocks AW, including during a same-cycle pop
    for (int k = 0; k < 4; k++) begin
      awvalid_i = 1; awaddr_i = 32'h1800 + k; awid_i = 16'h10 + k;
      #1;
      chk("fill_awready", awready_o, 1);
      edge_();
    end
    awid_i = 16'h14;
    #1;
    chk("full_awready", awready_o, 0);
    chk("full_awvalid_o", awvalid_o, 0);
    edge_();
    wvalid_i = 1; wlast_i = 1;
    #1;
    chk("full_pop_wready", wready_o, 1);
    chk("full_pop_awready", awready_o, 0);
    edge_();
    wvalid_i = 0; wlast_i = 0;
    #1;
    chk("after_pop_awready", awready_o, 1);
    chk("after_pop_awvalid", awvalid_o, 5'b00100);
    edge_();
    awvalid_i = 0;
    for (int k = 0; k < 4; k++) begin
      wvalid_i = 1; wlast_i = 1;
      #1;
      chk("drain_wvalid", wvalid_o, 5'b00100);
      chk("drain_wready", wready_o, 1);
      edge_();
    end
    idle();
    #1;
    chk("drain_empty_wready", wready_o, 0);

    // Push and pop together at count 2, then order across pointer wrap
    awvalid_i = 1; awaddr_i = 32'h2000; edge_();
    awaddr_i = 32'h0100; edge_();
    awaddr_i = 32'h1000; wvalid_i = 1; wlast_i = 1;
    #1;
    chk("pp_wvalid", wvalid_o, 5'b00010);
    chk("pp_awready", awready_o, 1);
    edge_();
    wvalid_i = 0; wlast_i = 0;
    awaddr_i = 32'h0FFF; edge_();
    awaddr_i = 32'h2FFF; edge_();
    awaddr_i = 32'h1800;
    #1;
    chk("pp_full_awready", awready_o, 0);
    awvalid_i = 0;
    begin
      logic [N-1:0] order [4];
      order[0] = 5'b00001; order[1] = 5'b00100; order[2] = 5'b00001; order[3] = 5'b00010;
      for (int k = 0; k < 4; k++) begin
        wvalid_i = 1; wlast_i = 1;
        #1;
        chk("wrap_order", wvalid_o, order[k]);
        edge_();
      end
    end
    idle();

    // Reset in the middle of a burst with a DECERR pending
    awvalid_i = 1; awaddr_i = 32'hF000; awid_i = 16'h3; edge_();
    awvalid_i = 0; wvalid_i = 1; wlast_i = 1; edge_();
    wvalid_i = 0; wlast_i = 0;
    awvalid_i = 1; awaddr_i = 32'h1800; awid_i = 16'h4; edge_();
    awvalid_i = 0; wvalid_i = 1; edge_();
    #1;
    chk("mid_pre_rst_wvalid", wvalid_o, 5'b00100);
    chk("mid_pre_rst_errv", err_bvalid_o, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_wvalid", wvalid_o, 0);
    chk("mid_rst_wready", wready_o, 0);
    chk("mid_rst_errv", err_bvalid_o, 0);
    chk("mid_rst_errid", err_bid_o, 0);
    edge_();
    rst_n = 1;
    #1;
    chk("mid_after_rst_wready", wready_o, 0);
    edge_();
    wvalid_i = 0;
    awvalid_i = 1; awaddr_i = 32'h2080; awid_i = 16'h6;
    #1;
    chk("resume_awvalid_o", awvalid_o, 5'b00010);
    edge_();
    awvalid_i = 0; wvalid_i = 1; wlast_i = 1;
    #1;
    chk("resume_wvalid_o", wvalid_o, 5'b00010);
    edge_();
    idle();

    // Randomized traffic against the outstanding-burst model
    rst_n = 0;
    edge_();
    rst_n = 1;
    m_errv = 0;
    m_eid = 0;
    bnd[0] = 32'h0FFF; bnd[1] = 32'h1000; bnd[2] = 32'h1FFF; bnd[3] = 32'h20FF;
    bnd[4] = 32'h2100; bnd[5] = 32'h2FFF; bnd[6] = 32'h3000; bnd[7] = 32'hFFFFFFFF;
    for (int c = 0; c < 400; c++) begin
      edge_();
      case ($urandom_range(0, 5))
        0, 1:    awaddr_i = bnd[$urandom_range(0, 7)];
        2:       awaddr_i = $urandom;
        default: awaddr_i = $urandom_range(0, 32'h4FFF);
      endcase
      awid_i = IDW'($urandom);
      awvalid_i = ($urandom_range(0, 1) == 1);
      awready_i = N'($urandom);
      wvalid_i = ($urandom_range(0, 1) == 1);
      wlast_i = ($urandom_range(0, 4) < 2);
      wready_i = N'($urandom) | N'($urandom);
      err_bready_i = ($urandom_range(0, 9) < 3);
      #1;
      m_decode(awaddr_i, m_hit, m_d);
      m_full = (q.size() == DEPTH);
      exp_awv = '0; exp_awr = 0;
      if (!m_full) begin
        if (m_hit) begin
          exp_awv[m_d] = awvalid_i;
          exp_awr = awready_i[m_d];
        end else exp_awr = 1;
      end
      exp_wv = '0; exp_wr = 0;
      if (q.size() > 0) begin
        if (q[0].err) exp_wr = !m_errv;
        else begin
          exp_wv = wvalid_i ? onehot(q[0].dest) : '0;
          exp_wr = wready_i[q[0].dest];
        end
      end
      chk("rnd_awvalid_o", awvalid_o, exp_awv);
      chk("rnd_awready_o", awready_o, exp_awr);
      chk("rnd_wvalid_o", wvalid_o, exp_wv);
      chk("rnd_wready_o", wready_o, exp_wr);
      chk("rnd_err_bvalid", err_bvalid_o, m_errv);
      if (m_errv) chk("rnd_err_bid", err_bid_o, m_eid);
      aw_hs = awvalid_i && exp_awr;
      pop = (q.size() > 0) && wvalid_i && exp_wr && wlast_i;
      if (m_errv && err_bready_i) m_errv = 0;
      if (pop) begin
        if (q[0].err) begin
          m_errv = 1;
          m_eid = q[0].id;
        end
        void'(q.pop_front());
      end
      if (aw_hs) begin
        e.err = !m_hit;
        e.dest = m_d;
        e.id = int'(awid_i);
        q.push_back(e);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
